// File: rtl/md5_msg_packer.sv
// -----------------------------------------------------------------------------
// md5_msg_packer
//   Feeds candidate messages to the pancham MD5 core. Bytes arrive on a
//   valid/ready stream (first byte first, s_last on the final byte). Each
//   message is packed right-justified into the core's [0:MSG_W-1] msg_in word,
//   the same layout a Verilog string literal produces ("lex" -> low 24 bits).
//   When the core is ready, msg_in_valid is strobed for one cycle. The packer
//   then holds msg_in/msg_in_width stable until core_out_valid reports the
//   digest.
//
//   Messages longer than MSG_W/8 bytes are dropped up to their last byte, and
//   set the sticky ovf_err. The first byte of the next message clears ovf_err.
//
// Configuration macro:
//   MD5_PACK_DBUF_EN - collect the next message into a shadow buffer while the
//                      core is hashing. When the core finishes, the shadow
//                      message moves straight to PEND.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   byte stream in
//   core_ready        pancham ready
//   core_out_valid    pancham digest done
//   msg_in            packed message (bit 0 = MSB)
//   msg_in_width      message length in bits
//   msg_in_valid      one-cycle launch strobe
//   ovf_err           sticky oversize-message flag
//   msg_count         messages launched since reset (wraps)
// -----------------------------------------------------------------------------
module md5_msg_packer #(
  parameter int MSG_W = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             core_ready,
  input  logic             core_out_valid,
  output logic [0:MSG_W-1] msg_in,
  output logic [7:0]       msg_in_width,
  output logic             msg_in_valid,
  output logic             ovf_err,
  output logic [CNT_W-1:0] msg_count
);

  localparam int MAX_B = MSG_W / 8;
  localparam int BC_W  = $clog2(MAX_B + 1);
  localparam logic [BC_W-1:0] MAX_CNT = BC_W'(MAX_B);

  // The collector (COLLECT/DROP) and the launcher (COLLECT=idle, PEND, ISSUE,
  // WAIT_DONE) share one encoding.
  localparam logic [2:0] COLLECT   = 3'd0;
  localparam logic [2:0] DROP      = 3'd1;
  localparam logic [2:0] PEND      = 3'd2;
  localparam logic [2:0] ISSUE     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  logic [2:0]       lst_q, lst_d;     // launcher state
  logic [2:0]       col_q, col_d;     // collector state
  logic [BC_W-1:0]  cnt_q, cnt_d;     // bytes stored in buf
  logic [0:MSG_W-1] buf_q, buf_d;     // collection buffer
  logic [0:MSG_W-1] msg_q, msg_d;     // message held for the core
  logic [7:0]       width_q, width_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q;            // keeps s_ready low during the first cycle after reset
`ifdef MD5_PACK_DBUF_EN
  logic             full_q, full_d;   // buf holds a completed message waiting for the core
`endif

  logic             xfer;
  logic             done;
  logic [BC_W-1:0]  cnt_inc;
  logic [0:MSG_W-1] base;
  logic [0:MSG_W-1] buf_new;

  function automatic logic [7:0] width_of(input logic [BC_W-1:0] c);
    return 8'({c, 3'b000});
  endfunction

`ifdef MD5_PACK_DBUF_EN
  assign s_ready = run_q && !full_q;
`else
  assign s_ready = run_q && (lst_q == COLLECT);
`endif

  assign xfer    = s_valid && s_ready;
  assign cnt_inc = cnt_q + BC_W'(1);
  // The first byte of a message starts from an empty buffer.
  assign base    = (cnt_q == '0) ? '0 : buf_q;
  assign buf_new = {base[8:MSG_W-1], s_data};

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    lst_d   = lst_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    msg_d   = msg_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    done    = 1'b0;
`ifdef MD5_PACK_DBUF_EN
    full_d  = full_q;
`endif

    // Collector.
    if (xfer) begin
      if (col_q == DROP) begin
        if (s_last) begin
          col_d = COLLECT;
          cnt_d = '0;
        end
      end else if (cnt_q == MAX_CNT) begin
        // Byte past a full buffer with no earlier last: the message is oversize.
        ovf_d = 1'b1;
        cnt_d = '0;
        if (!s_last) col_d = DROP;
      end else begin
        if (cnt_q == '0) ovf_d = 1'b0;
        buf_d = buf_new;
        cnt_d = cnt_inc;
        done  = s_last;
      end
    end

    // Hand a completed message to the launcher.
    if (done) begin
`ifdef MD5_PACK_DBUF_EN
      if (lst_q == COLLECT) begin
        msg_d   = buf_new;
        width_d = width_of(cnt_inc);
        cnt_d   = '0;
        lst_d   = PEND;
      end else begin
        full_d  = 1'b1;               // buf/cnt keep the message until the core frees up
      end
`else
      msg_d   = buf_new;
      width_d = width_of(cnt_inc);
      cnt_d   = '0;
      lst_d   = PEND;
`endif
    end

    // Launcher.
    case (lst_q)
      PEND:      if (core_ready) lst_d = ISSUE;
      ISSUE: begin
        lst_d   = WAIT_DONE;
        count_d = count_q + CNT_W'(1);
      end
      WAIT_DONE: if (core_out_valid) lst_d = COLLECT;
      default:   ;
    endcase

`ifdef MD5_PACK_DBUF_EN
    // The shadow message moves to PEND as soon as the launcher is free.
    if (full_q && ((lst_q == COLLECT) || ((lst_q == WAIT_DONE) && core_out_valid))) begin
      msg_d   = buf_q;
      width_d = width_of(cnt_q);
      cnt_d   = '0;
      full_d  = 1'b0;
      lst_d   = PEND;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lst_q   <= COLLECT;
      col_q   <= COLLECT;
      cnt_q   <= '0;
      buf_q   <= '0;
      msg_q   <= '0;
      width_q <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      run_q   <= 1'b0;
`ifdef MD5_PACK_DBUF_EN
      full_q  <= 1'b0;
`endif
    end else begin
      lst_q   <= lst_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      msg_q   <= msg_d;
      width_q <= width_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      run_q   <= 1'b1;
`ifdef MD5_PACK_DBUF_EN
      full_q  <= full_d;
`endif
    end
  end

  assign msg_in       = msg_q;
  assign msg_in_width = width_q;
  assign msg_in_valid = (lst_q == ISSUE);
  assign ovf_err      = ovf_q;
  assign msg_count    = count_q;

endmodule

// File: tb/tb_md5_msg_packer.sv
// -----------------------------------------------------------------------------
// tb_md5_msg_packer
//   Self-checking bench for md5_msg_packer. A table of messages with
//   hand-computed packed words and widths is replayed. Hand-written sequences
//   then cover:
//     - launch latency
//     - oversize drop
//     - core_ready back-pressure
//     - reset in the middle of a message
//     - back-to-back messages
//   A small core model answers each launch with core_out_valid after a few
//   cycles.
// -----------------------------------------------------------------------------
module tb_md5_msg_packer;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic           core_ready;
  logic           core_out_valid;
  logic [0:127]   msg_in;
  logic [7:0]     msg_in_width;
  logic           msg_in_valid;
  logic           ovf_err;
  logic [15:0]    msg_count;

  md5_msg_packer #(.MSG_W(128), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .core_ready     (core_ready),
    .core_out_valid (core_out_valid),
    .msg_in         (msg_in),
    .msg_in_width   (msg_in_width),
    .msg_in_valid   (msg_in_valid),
    .ovf_err        (ovf_err),
    .msg_count      (msg_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Core model and launch monitor (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  int           core_lat  = 3;
  int           pulse_cnt = 0;
  int           done_cnt  = 0;
  int           order_err = 0;
  bit           busy      = 0;
  int           tmr       = 0;
  logic [127:0] m_log[$];
  logic [7:0]   w_log[$];

  initial core_out_valid = 1'b0;

  always @(negedge clk) begin
    core_out_valid = 1'b0;
    if (!reset_n) begin
      busy = 0;
    end else if (msg_in_valid) begin
      if (pulse_cnt != done_cnt) order_err++;   // launch before previous digest
      pulse_cnt++;
      m_log.push_back(msg_in);
      w_log.push_back(msg_in_width);
      busy = 1;
      tmr  = core_lat;
    end else if (busy) begin
      if (tmr == 0) begin
        core_out_valid = 1'b1;
        busy = 0;
        done_cnt++;
      end else begin
        tmr--;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: all start and end at negedge + 1
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input string m, input bit with_last);
    for (int i = 0; i < m.len(); i++) begin
      int t = 0;
      s_data  = m[i];
      s_valid = 1'b1;
      s_last  = with_last && (i == m.len() - 1);
      while (!s_ready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) begin
        check("s_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    int t = 0;
    while (pulse_cnt < target && t < 200) begin
      step();
      t++;
    end
    if (pulse_cnt < target) check("pulse_timeout", pulse_cnt, target);
  endtask

  task automatic wait_quiet();
    int t = 0;
    while (!(s_ready && !busy && pulse_cnt == done_cnt) && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) check("quiet_timeout", 0, 1);
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_msg_in"},  msg_in,       0);
    check({tag, "_width"},   msg_in_width, 0);
    check({tag, "_valid"},   msg_in_valid, 0);
    check({tag, "_s_ready"}, s_ready,      0);
    check({tag, "_ovf"},     ovf_err,      0);
    check({tag, "_count"},   msg_count,    0);
  endtask

  typedef struct {
    string        s;
    logic [127:0] m;
    logic [7:0]   w;
  } vec_t;

  vec_t vecs[7];
  int   exp_count;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic exp_busy_ready;

    vecs[0] = '{"lex",              128'h6c6578,                           8'd24};
    vecs[1] = '{"akha",             128'h616b6861,                         8'd32};
    vecs[2] = '{"vader",            128'h7661646572,                       8'd40};
    vecs[3] = '{"coffee",           128'h636f66666565,                     8'd48};
    vecs[4] = '{"jackson",          128'h6a61636b736f6e,                   8'd56};
    vecs[5] = '{"0123456789abcdef", 128'h30313233343536373839616263646566, 8'd128};
    vecs[6] = '{"a",                128'h61,                               8'd8};

`ifdef MD5_PACK_DBUF_EN
    exp_busy_ready = 1'b1;
`else
    exp_busy_ready = 1'b0;
`endif

    // Reset state, and s_ready rising one cycle after release.
    reset_n    = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    s_data     = 8'h00;
    core_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    check("s_ready_at_release", s_ready, 0);
    step();
    check("s_ready_after_release", s_ready, 1);
    exp_count = 0;

    // Table of messages, each launched and digested in turn.
    for (int i = 0; i < 7; i++) begin
      base = pulse_cnt;
      send(vecs[i].s, 1'b1);
      check($sformatf("busy_s_ready_%0d", i), s_ready, exp_busy_ready);
      wait_pulses(base + 1);
      if (pulse_cnt > base) begin
        check($sformatf("width_%s", vecs[i].s), w_log[base], vecs[i].w);
        check($sformatf("msg_%s", vecs[i].s), m_log[base], vecs[i].m);
      end
      wait_quiet();
      exp_count++;
      check($sformatf("one_pulse_%s", vecs[i].s), pulse_cnt, base + 1);
      check($sformatf("count_%s", vecs[i].s), msg_count, exp_count);
    end
    check("launch_order", order_err, 0);

    // Latency: the PEND cycle follows the last transfer, then a one-cycle strobe.
    send("lex", 1'b1);
    check("lat_pend_valid", msg_in_valid, 0);
    check("lat_pend_width", msg_in_width, 24);
    step();
    check("lat_issue_valid", msg_in_valid, 1);
    step();
    check("lat_after_valid", msg_in_valid, 0);
    wait_quiet();
    exp_count++;

    // 17 bytes ending with last: dropped, ovf set, no launch.
    base = pulse_cnt;
    send("0123456789abcdefg", 1'b1);
    check("ovf17_flag", ovf_err, 1);
    repeat (10) step();
    check("ovf17_no_pulse", pulse_cnt, base);
    check("ovf17_s_ready", s_ready, 1);

    // 18 bytes: DROP until last, still no launch.
    send("0123456789abcdefgh", 1'b1);
    repeat (5) step();
    check("ovf18_flag", ovf_err, 1);
    check("ovf18_no_pulse", pulse_cnt, base);

    // Next valid message clears ovf and launches normally.
    send("lex", 1'b1);
    check("ovf_cleared", ovf_err, 0);
    wait_pulses(base + 1);
    if (pulse_cnt > base) check("after_ovf_width", w_log[base], 24);
    wait_quiet();
    exp_count++;
    check("after_ovf_count", msg_count, exp_count);

    // Core not ready for 20 cycles: held in PEND with stable message.
    core_ready = 1'b0;
    base = pulse_cnt;
    send("lex", 1'b1);
    for (int c = 0; c < 20; c++) begin
      check("hold_no_valid", msg_in_valid, 0);
      check("hold_msg", msg_in, 128'h6c6578);
      check("hold_width", msg_in_width, 24);
      check("hold_s_ready", s_ready, exp_busy_ready);
      step();
    end
    check("hold_no_pulse", pulse_cnt, base);
    core_ready = 1'b1;
    step();
    check("ready_rise_pulse", msg_in_valid, 1);
    wait_quiet();
    exp_count++;
    check("hold_count", msg_count, exp_count);

    // Reset in the middle of a message.
    send("va", 1'b0);
    reset_n = 1'b0;
    step();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    step();
    exp_count = 0;
    base = pulse_cnt;
    send("lex", 1'b1);
    wait_pulses(base + 1);
    if (pulse_cnt > base) begin
      check("post_reset_width", w_log[base], 24);
      check("post_reset_msg", m_log[base], 128'h6c6578);
    end
    wait_quiet();
    exp_count++;
    check("post_reset_count", msg_count, exp_count);

    // Back-to-back: with the shadow buffer the second message is collected
    // during the first hash.
    core_lat = 10;
    base = pulse_cnt;
    send("akha", 1'b1);
    check("b2b_s_ready", s_ready, exp_busy_ready);
    send("vader", 1'b1);
    wait_pulses(base + 2);
    if (pulse_cnt >= base + 2) begin
      check("b2b_width0", w_log[base], 32);
      check("b2b_width1", w_log[base + 1], 40);
      check("b2b_msg1", m_log[base + 1], 128'h7661646572);
    end
    wait_quiet();
    exp_count += 2;
    check("b2b_count", msg_count, exp_count);
    check("b2b_order", order_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
